// File: rtl/udi_issue_ctl_if.sv
// udi_issue_ctl_if: command (cmd_*) and response (rsp_*) valid/ready channels; master = requester, slave = issue controller
interface udi_issue_ctl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_func;
  logic [4:0]  cmd_rd;
  logic [31:0] cmd_rs;
  logic [31:0] cmd_rt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_wrreg;
  logic        rsp_ri;
  logic        rsp_tmo;
  modport master (
    output cmd_valid, cmd_func, cmd_rd, cmd_rs, cmd_rt, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_wrreg, rsp_ri, rsp_tmo
  );
  modport slave (
    input  cmd_valid, cmd_func, cmd_rd, cmd_rs, cmd_rt, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_wrreg, rsp_ri, rsp_tmo
  );
endinterface

// File: rtl/udi_issue_ctl.sv
// udi_issue_ctl: UDI initiator; bus = cmd/rsp handshakes, UDI_*_e/UDI_*_m = E/M stage responder signalling, one command in flight
module udi_issue_ctl #(
  parameter logic [5:0] MAJ_OP     = 6'd28,
  parameter int         TIMEOUT    = 255,
  parameter logic       KD_MODE    = 1'b1,
  parameter logic       ENDIAN_BIG = 1'b0
) (
  input  logic        UDI_gclk,
  input  logic        UDI_greset_n,
  udi_issue_ctl_if.slave bus,
  output logic [31:0] UDI_ir_e,
  output logic        UDI_irvalid_e,
  output logic        UDI_start_e,
  output logic [31:0] UDI_rs_e,
  output logic [31:0] UDI_rt_e,
  output logic        UDI_endianb_e,
  output logic        UDI_kd_mode_e,
  output logic        UDI_run_m,
  output logic        UDI_kill_m,
  output logic        UDI_greset,
  output logic        UDI_gscanenable,
  input  logic [31:0] UDI_rd_m,
  input  logic [4:0]  UDI_wrreg_e,
  input  logic        UDI_ri_e,
  input  logic        UDI_stall_m,
  input  logic        UDI_present
);
  typedef enum logic [2:0] {IDLE, EXEC, MEM, KILL, RESP} state_t;
  localparam logic [15:0] TMO_M1 = 16'(TIMEOUT - 1);
  state_t      state;
  logic [15:0] cnt;
  assign bus.cmd_ready   = UDI_greset_n && state == IDLE;
  assign bus.rsp_valid   = state == RESP;
  assign UDI_endianb_e   = ENDIAN_BIG;
  assign UDI_kd_mode_e   = KD_MODE;
  assign UDI_greset      = ~UDI_greset_n;
  assign UDI_gscanenable = 1'b0;
  always_ff @(posedge UDI_gclk or negedge UDI_greset_n)
    if (!UDI_greset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      UDI_ir_e      <= '0;
      UDI_rs_e      <= '0;
      UDI_rt_e      <= '0;
      UDI_irvalid_e <= 1'b0;
      UDI_start_e   <= 1'b0;
      UDI_run_m     <= 1'b0;
      UDI_kill_m    <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_wrreg <= '0;
      bus.rsp_ri    <= 1'b0;
      bus.rsp_tmo   <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.cmd_valid && UDI_present) begin
            state         <= EXEC;
            UDI_ir_e      <= {MAJ_OP, 10'd0, bus.cmd_rd, 5'd0, bus.cmd_func};
            UDI_rs_e      <= bus.cmd_rs;
            UDI_rt_e      <= bus.cmd_rt;
            UDI_irvalid_e <= 1'b1;
            UDI_start_e   <= 1'b1;
          end else if (bus.cmd_valid) begin
            state         <= RESP;
            bus.rsp_ri    <= 1'b1;
            bus.rsp_data  <= '0;
            bus.rsp_wrreg <= '0;
          end
        EXEC: begin
          state         <= MEM;
          UDI_irvalid_e <= 1'b0;
          UDI_start_e   <= 1'b0;
          UDI_run_m     <= 1'b1;
          UDI_kill_m    <= UDI_ri_e;
          bus.rsp_ri    <= UDI_ri_e;
          bus.rsp_wrreg <= UDI_wrreg_e;
        end
        MEM:
          if (bus.rsp_ri) begin
            state        <= RESP;
            UDI_run_m    <= 1'b0;
            UDI_kill_m   <= 1'b0;
            bus.rsp_data <= '0;
          end else if (UDI_stall_m) begin
            cnt <= cnt + 16'd1;
            if (cnt == TMO_M1) begin
              state      <= KILL;
              UDI_kill_m <= 1'b1;
            end
          end else begin
            state        <= RESP;
            UDI_run_m    <= 1'b0;
            bus.rsp_data <= UDI_rd_m;
          end
        KILL: begin
          state        <= RESP;
          UDI_run_m    <= 1'b0;
          UDI_kill_m   <= 1'b0;
          bus.rsp_tmo  <= 1'b1;
          bus.rsp_data <= '0;
        end
        RESP:
          if (bus.rsp_ready) begin
            state       <= IDLE;
            bus.rsp_ri  <= 1'b0;
            bus.rsp_tmo <= 1'b0;
            cnt         <= '0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_udi_issue_ctl.sv
// tb_udi_issue_ctl: scoreboard bench with a behavioural UDI responder stub
module tb_udi_issue_ctl;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  udi_issue_ctl_if bus();
  logic [31:0] ir_e, rs_e, rt_e, rd_m;
  logic        irvalid_e, start_e, endianb_e, kd_mode_e, run_m, kill_m, greset, gscan;
  logic [4:0]  wrreg_e;
  logic        ri_e, stall_m, present;
  udi_issue_ctl #(.TIMEOUT(TMO)) dut (
    .UDI_gclk(clk), .UDI_greset_n(rst_n), .bus(bus),
    .UDI_ir_e(ir_e), .UDI_irvalid_e(irvalid_e), .UDI_start_e(start_e),
    .UDI_rs_e(rs_e), .UDI_rt_e(rt_e), .UDI_endianb_e(endianb_e), .UDI_kd_mode_e(kd_mode_e),
    .UDI_run_m(run_m), .UDI_kill_m(kill_m), .UDI_greset(greset), .UDI_gscanenable(gscan),
    .UDI_rd_m(rd_m), .UDI_wrreg_e(wrreg_e), .UDI_ri_e(ri_e), .UDI_stall_m(stall_m),
    .UDI_present(present)
  );
  typedef struct {
    logic [31:0] data;
    logic [4:0]  wrreg;
    logic        chk_wr;
    logic        ri;
    logic        tmo;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stall_n = 0;
  bit stall_inf = 1'b0;
  int stall_left = 0;
  logic [31:0] res = 32'h0;
  logic [31:0] thr = 32'h0;
  int kill_cnt = 0;
  int kill_cyc = 0;
  int irv_cnt = 0;
  int rv_cnt = 0;
  int first_v = 0;
  logic rv_d = 1'b0;
  logic [5:0]  cur_f = '0;
  logic [4:0]  cur_rd = '0;
  logic [31:0] cur_rs = '0;
  logic [31:0] cur_rt = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic is_ri(input logic [5:0] f);
    return !(f inside {6'd16, 6'd17, 6'd19, 6'd20});
  endfunction
  function automatic logic [31:0] calc(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] t);
    logic [31:0] a, b, sq;
    a = rs >> 16;
    b = rt >> 16;
    sq = a * a + b * b;
    case (f)
      6'd16:   return sq;
      6'd17:   return 32'hDEAD_BEEF;
      6'd19:   return 32'h0;
      6'd20:   return {31'd0, sq > t};
      default: return 32'hBAD0_BAD0;
    endcase
  endfunction
  function automatic exp_t mk(input logic [31:0] d, input logic [4:0] w, input logic cw, input logic r, input logic t, input int l);
    exp_t e;
    e.data = d; e.wrreg = w; e.chk_wr = cw; e.ri = r; e.tmo = t; e.lat = l; e.acc = 0;
    return e;
  endfunction
  assign ri_e    = irvalid_e && is_ri(ir_e[5:0]);
  assign wrreg_e = (irvalid_e && !ri_e && ir_e[5:0] != 6'd19) ? ir_e[15:11] : 5'd0;
  assign stall_m = run_m && !kill_m && (stall_inf || stall_left > 0);
  assign rd_m    = run_m ? res : 32'h0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) stall_left <= 0;
    else if (irvalid_e) begin
      stall_left <= stall_n;
      res <= calc(ir_e[5:0], rs_e, rt_e, thr);
      if (ir_e[5:0] == 6'd19) thr <= rs_e;
    end else if (stall_m) stall_left <= stall_left - 1;
  end
  always @(negedge clk)
    if (rst_n) begin
      if (kill_m) begin kill_cnt++; kill_cyc = cyc; end
      if (irvalid_e) begin
        irv_cnt++;
        chk("ir_e", ir_e, {6'd28, 10'd0, cur_rd, 5'd0, cur_f});
        chk("rs_e", rs_e, cur_rs);
        chk("rt_e", rt_e, cur_rt);
        chk("start_e", {31'd0, start_e}, 32'd1);
      end
      if (bus.rsp_valid) begin
        rv_cnt++;
        if (!rv_d) first_v = cyc;
      end
      rv_d = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_ri", {31'd0, bus.rsp_ri}, {31'd0, e.ri});
          chk("rsp_tmo", {31'd0, bus.rsp_tmo}, {31'd0, e.tmo});
          if (e.chk_wr) chk("rsp_wrreg", {27'd0, bus.rsp_wrreg}, {27'd0, e.wrreg});
          chk("rsp_latency", first_v - e.acc, e.lat);
        end
      end
    end else rv_d = 1'b0;
  task automatic send(input logic [5:0] f, input logic [4:0] rd, input logic [31:0] rs, input logic [31:0] rt,
                      input exp_t e, input bit push, output int acc);
    int n = 0;
    acc = 0;
    @(negedge clk);
    bus.cmd_func = f; bus.cmd_rd = rd; bus.cmd_rs = rs; bus.cmd_rt = rt; bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      cur_f = f; cur_rd = rd; cur_rs = rs; cur_rt = rt;
      acc = cyc;
      e.acc = cyc;
      if (push) q.push_back(e);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.rsp_valid) && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      chk("rsp_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int acc;
    int n;
    bit hold_ok;
    bus.cmd_valid = 1'b0; bus.cmd_func = '0; bus.cmd_rd = '0; bus.cmd_rs = '0; bus.cmd_rt = '0;
    bus.rsp_ready = 1'b1;
    present = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_ue_ctl", {27'd0, irvalid_e, start_e, run_m, kill_m, gscan}, 32'd0);
    chk("rst_ir_e", ir_e, 32'd0);
    chk("rst_greset", {31'd0, greset}, 32'd1);
    chk("rst_const", {30'd0, endianb_e, kd_mode_e}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("greset_off", {31'd0, greset}, 32'd0);
    kill_cnt = 0;
    send(6'd16, 5'd3, 32'h0003_0000, 32'h0004_0000, mk(32'd25, 5'd3, 1'b1, 1'b0, 1'b0, 3), 1'b1, acc);
    drain();
    chk("basic_no_kill", kill_cnt, 32'd0);
    send(6'd19, 5'd4, 32'd20, 32'd0, mk(32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3), 1'b1, acc);
    drain();
    send(6'd20, 5'd5, 32'h0003_0000, 32'h0004_0000, mk(32'd1, 5'd5, 1'b1, 1'b0, 1'b0, 3), 1'b1, acc);
    drain();
    send(6'd19, 5'd4, 32'd30, 32'd0, mk(32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3), 1'b1, acc);
    drain();
    send(6'd20, 5'd5, 32'h0003_0000, 32'h0004_0000, mk(32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3), 1'b1, acc);
    drain();
    kill_cnt = 0;
    send(6'h17, 5'd7, 32'd1, 32'd2, mk(32'd0, 5'd0, 1'b1, 1'b1, 1'b0, 3), 1'b1, acc);
    drain();
    chk("ri_kill_cnt", kill_cnt, 32'd1);
    chk("ri_kill_cyc", kill_cyc - acc, 32'd2);
    stall_n = 5;
    kill_cnt = 0;
    send(6'd17, 5'd9, 32'd0, 32'd0, mk(32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0, 1'b0, 8), 1'b1, acc);
    drain();
    chk("stall_no_kill", kill_cnt, 32'd0);
    stall_n = 0;
    stall_inf = 1'b1;
    kill_cnt = 0;
    send(6'd16, 5'd3, 32'h0003_0000, 32'h0004_0000, mk(32'd0, 5'd3, 1'b1, 1'b0, 1'b1, TMO + 3), 1'b1, acc);
    drain();
    chk("tmo_kill_cnt", kill_cnt, 32'd1);
    chk("tmo_kill_cyc", kill_cyc - acc, TMO + 2);
    stall_inf = 1'b0;
    send(6'd16, 5'd8, 32'h0001_0000, 32'h0002_0000, mk(32'd5, 5'd8, 1'b1, 1'b0, 1'b0, 3), 1'b1, acc);
    drain();
    bus.rsp_ready = 1'b0;
    send(6'd16, 5'd6, 32'h0001_0000, 32'h0002_0000, mk(32'd5, 5'd6, 1'b1, 1'b0, 1'b0, 3), 1'b1, acc);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    hold_ok = 1'b1;
    repeat (10) begin
      if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_data !== 32'd5 || bus.rsp_wrreg !== 5'd6) hold_ok = 1'b0;
      @(negedge clk);
    end
    chk("hold_stable", {31'd0, hold_ok}, 32'd1);
    bus.rsp_ready = 1'b1;
    drain();
    stall_n = 20;
    send(6'd17, 5'd2, 32'd0, 32'd0, mk(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 0), 1'b0, acc);
    @(negedge clk);
    chk("mid_mem_run", {31'd0, run_m}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {28'd0, irvalid_e, start_e, run_m, kill_m}, 32'd0);
    chk("midrst_ir_e", ir_e, 32'd0);
    chk("midrst_hs", {30'd0, bus.cmd_ready, bus.rsp_valid}, 32'd0);
    chk("midrst_greset", {31'd0, greset}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stall_n = 0;
    rv_cnt = 0;
    repeat (12) @(negedge clk);
    chk("midrst_no_rsp", rv_cnt, 32'd0);
    chk("midrst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    present = 1'b0;
    irv_cnt = 0;
    send(6'd16, 5'd3, 32'h0003_0000, 32'h0004_0000, mk(32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1), 1'b1, acc);
    drain();
    chk("absent_no_irvalid", irv_cnt, 32'd0);
    present = 1'b1;
    send(6'd16, 5'd3, 32'h0003_0000, 32'h0004_0000, mk(32'd25, 5'd3, 1'b1, 1'b0, 1'b0, 3), 1'b1, acc);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
